ram_arbiter: RTL and testbench

//   Shares the single CPU-side port of the data RAM between two masters: M0 = CPU memory stage,
//   M1 = loader/DMA engine. Latches one request at a time, drives the RAM port for one cycle,

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arb_pick.sv | 34 +++
 rtl/ram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the data-RAM arbiter: FSM encoding, master indices
// and the streak-counter width helper.
package ram_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Counter wide enough to hold 0..max_burst inclusive.
    function automatic int unsigned streak_width(input int unsigned max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the two-master RAM arbiter.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned STREAK_W  = 3
) (
    input  logic                m0_req_i,
    input  logic                m1_req_i,
    input  logic [STREAK_W-1:0] streak_i,
    input  logic                excl_en_i,
    input  logic                excl_idx_i,
    output logic                valid_o,
    output logic                winner_o
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_BURST);

    logic pref;

    // The normal winner is chosen first; if it is the master just acked,
    // nothing is granted so that master gets a fresh IDLE arbitration.
    always_comb begin
        pref = M0;
        if (m0_req_i && m1_req_i) begin
            pref = (streak_i == STREAK_MAX) ? M1 : M0;
        end else if (m1_req_i) begin
            pref = M1;
        end
        valid_o  = (m0_req_i || m1_req_i) && !(excl_en_i && (pref == excl_idx_i));
        winner_o = pref;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the data RAM's CPU-side port between the CPU memory stage (M0)
// and the loader/DMA engine (M1); one latched access at a time.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W/8-1:0]   m0_sel,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_stall,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W/8-1:0]   m1_sel,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W/8-1:0]   ram_sel,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int unsigned SEL_W    = DATA_W / 8;
    localparam int unsigned STREAK_W = streak_width(MAX_BURST);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_BURST);

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic pick_valid;
    logic pick_winner;
    logic grant;
    logic in_access;
    logic in_resp;

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    ram_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .STREAK_W  (STREAK_W)
    ) u_pick (
        .m0_req_i   (m0_req),
        .m1_req_i   (m1_req),
        .streak_i   (streak_q),
        .excl_en_i  (in_resp),
        .excl_idx_i (gnt_q),
        .valid_o    (pick_valid),
        .winner_o   (pick_winner)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        streak_d   = streak_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        grant      = 1'b0;

        case (state_q)
            IDLE: begin
                grant = pick_valid;
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    if (gnt_q == M0) begin
                        m0_rdata_d = ram_rdata;
                    end else begin
                        m1_rdata_d = ram_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                grant   = pick_valid;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant) begin
            state_d = ACCESS;
            gnt_d   = pick_winner;
            if (pick_winner == M0) begin
                we_d    = m0_we;
                addr_d  = m0_addr;
                sel_d   = m0_sel;
                wdata_d = m0_wdata;
                // Streak only grows while M1 is actually being held off.
                if (!m1_req) begin
                    streak_d = '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end else begin
                we_d     = m1_we;
                addr_d   = m1_addr;
                sel_d    = m1_sel;
                wdata_d  = m1_wdata;
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= M0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            wdata_q    <= '0;
            streak_q   <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            streak_q   <= streak_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Enables are gated by rst so a reset landing on an ACCESS cycle cannot write.
    assign ram_en    = in_access && !rst;
    assign ram_we    = in_access && !rst && we_q;
    assign ram_addr  = in_access ? addr_q  : '0;
    assign ram_sel   = in_access ? sel_q   : '0;
    assign ram_wdata = in_access ? wdata_q : '0;

    assign m0_ack   = in_resp && (gnt_q == M0) && !rst;
    assign m1_ack   = in_resp && (gnt_q == M1) && !rst;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_stall = m0_req && !m0_ack;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized checks of ram_arbiter against a word-level memory model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack, m0_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_sel    (m0_sel),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m0_stall  (m0_stall),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_sel    (m1_sel),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_sel   (ram_sel),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Environment RAM: 16 words, byte-lane writes, combinational read.
    logic [31:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel[b]) ram_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end
    assign ram_rdata = ram_mem[ram_addr[5:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_m(input int m, input logic req, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = a; m0_sel = s; m0_wdata = d;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a; m1_sel = s; m1_wdata = d;
        end
    endtask

    function automatic logic ack_of(input int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic [31:0] rdata_of(input int m);
        return (m == 0) ? m0_rdata : m1_rdata;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Single bounded transaction; returns rdata as seen in the ack cycle.
    task automatic txn(input int m, input logic we, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd);
        int unsigned waited;
        waited = 0;
        set_m(m, 1, we, a, s, d);
        do begin
            cyc();
            waited++;
        end while (!ack_of(m) && waited < 20);
        chk1("txn_ack", ack_of(m), 1'b1);
        rd = rdata_of(m);
        set_m(m, 0, 0, '0, '0, '0);
        cyc();
    endtask

    logic [31:0] rd;
    logic        ord [10];
    int          at [10];
    int          n_acc;
    int          cnt_en, cnt_ack;
    logic [31:0] ref_mem [16];
    logic [31:0] last_rd [2];
    logic        act [2];
    logic        r_we [2];
    logic [31:0] r_addr [2];
    logic [3:0]  r_sel [2];
    logic [31:0] r_wd [2];
    int          r_wait [2];
    int          r_gap [2];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
        cyc();
        chk1("rst_ram_en", ram_en, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_sel", {28'h0, ram_sel}, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk1("rst_m0_ack", m0_ack, 1'b0);
        chk1("rst_m1_ack", m1_ack, 1'b0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        cyc();
        rst = 1'b0;

        // M0 read timing
        txn(1, 1, 32'h10, 4'hF, 32'hDEADBEEF, rd);
        set_m(0, 1, 0, 32'h10, 4'h0, 32'h0);
        #1;
        chk1("t1_stall_n", m0_stall, 1'b1);
        chk1("t1_en_n", ram_en, 1'b0);
        cyc();
        chk1("t1_en_n1", ram_en, 1'b1);
        chk1("t1_we_n1", ram_we, 1'b0);
        chk("t1_addr_n1", ram_addr, 32'h10);
        chk1("t1_stall_n1", m0_stall, 1'b1);
        chk1("t1_ack_n1", m0_ack, 1'b0);
        cyc();
        chk1("t1_ack_n2", m0_ack, 1'b1);
        chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        chk1("t1_stall_n2", m0_stall, 1'b0);
        chk1("t1_en_n2", ram_en, 1'b0);
        m0_req = 1'b0;
        cyc();
        chk1("t1_ack_n3", m0_ack, 1'b0);
        chk("t1_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // M1 partial write
        txn(1, 1, 32'h20, 4'hF, 32'hAABBCCDD, rd);
        txn(1, 1, 32'h24, 4'hF, 32'h55667788, rd);
        txn(1, 0, 32'h24, 4'h0, 32'h0, rd);
        chk("t2_read24", rd, 32'h55667788);
        txn(1, 1, 32'h20, 4'b0101, 32'h11223344, rd);
        chk("t2_wr_rdata_kept", rd, 32'h55667788);
        chk("t2_mem_word", ram_mem[8], 32'hAA22CC44);
        txn(1, 0, 32'h20, 4'h0, 32'h0, rd);
        chk("t2_readback", rd, 32'hAA22CC44);

        // Both held: grant order and spacing
        do_reset();
        set_m(0, 1, 0, 32'h0, 4'h0, 32'h0);
        set_m(1, 1, 0, 32'h4, 4'h0, 32'h0);
        n_acc = 0;
        for (int c = 0; c < 80 && n_acc < 10; c++) begin
            cyc();
            if (ram_en) begin
                ord[n_acc] = (ram_addr == 32'h4);
                at[n_acc] = c;
                n_acc++;
            end
        end
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
        chk("t3_count", n_acc, 10);
        for (int i = 0; i < n_acc; i++) begin
            chk1("t3_order", ord[i], ((i + 1) % 5) == 0);
            if (i > 0) chk("t3_gap", at[i] - at[i-1], (ord[i] == ord[i-1]) ? 3 : 2);
        end

        // Streak clears when M0 wins with M1 idle
        do_reset();
        set_m(0, 1, 0, 32'h0, 4'h0, 32'h0);
        set_m(1, 1, 0, 32'h4, 4'h0, 32'h0);
        n_acc = 0;
        for (int c = 0; c < 80 && n_acc < 9; c++) begin
            cyc();
            if (ram_en) begin
                ord[n_acc] = (ram_addr == 32'h4);
                n_acc++;
                if (n_acc == 3) m1_req = 1'b0;
                if (n_acc == 4) m1_req = 1'b1;
            end
        end
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
        chk("t4_count", n_acc, 9);
        for (int i = 0; i < n_acc; i++) chk1("t4_order", ord[i], i == 8);

        // Reset during a write's ACCESS cycle
        do_reset();
        txn(1, 1, 32'h30, 4'hF, 32'h12345678, rd);
        txn(1, 0, 32'h30, 4'h0, 32'h0, rd);
        chk("t5_pre_read", rd, 32'h12345678);
        set_m(0, 1, 1, 32'h30, 4'hF, 32'hFFFFFFFF);
        cyc();
        chk1("t5_en_access", ram_en, 1'b1);
        chk1("t5_we_access", ram_we, 1'b1);
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        chk1("t5_en_gated", ram_en, 1'b0);
        chk1("t5_we_gated", ram_we, 1'b0);
        cyc();
        chk1("t5_ack", m0_ack, 1'b0);
        chk1("t5_en", ram_en, 1'b0);
        chk("t5_addr", ram_addr, 32'h0);
        chk("t5_wdata", ram_wdata, 32'h0);
        chk("t5_m1_rdata", m1_rdata, 32'h0);
        chk("t5_mem", ram_mem[12], 32'h12345678);
        rst = 1'b0;
        cyc();
        chk1("t5_ack_after", m0_ack, 1'b0);
        set_m(0, 1, 0, 32'h30, 4'h0, 32'h0);
        cyc();
        chk1("t5_idle_en", ram_en, 1'b1);
        cyc();
        chk1("t5_idle_ack", m0_ack, 1'b1);
        chk("t5_idle_rdata", m0_rdata, 32'h12345678);
        m0_req = 1'b0;
        cyc();

        // Request dropped after latching
        set_m(0, 1, 0, 32'h10, 4'h0, 32'h0);
        cyc();
        chk1("t6_en", ram_en, 1'b1);
        m0_req = 1'b0;
        cnt_en = 0;
        cnt_ack = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (ram_en) cnt_en++;
            if (m0_ack) cnt_ack++;
            if (c == 0) chk("t6_rdata", m0_rdata, 32'hDEADBEEF);
        end
        chk("t6_acks", cnt_ack, 1);
        chk("t6_extra_access", cnt_en, 0);

        // Randomized traffic against a word-level memory model
        do_reset();
        for (int w = 0; w < 16; w++) begin
            ref_mem[w] = $urandom;
            txn(w % 2, 1, 32'(w * 4), 4'hF, ref_mem[w], rd);
        end
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = '0;
            act[k] = 1'b0;
            r_gap[k] = 0;
        end
        for (int c = 0; c < 700; c++) begin
            cyc();
            for (int k = 0; k < 2; k++) begin
                if (act[k]) begin
                    if (ack_of(k)) begin
                        if (r_we[k]) begin
                            for (int b = 0; b < 4; b++)
                                if (r_sel[k][b]) ref_mem[r_addr[k][5:2]][8*b +: 8] = r_wd[k][8*b +: 8];
                            chk("rnd_wr_rdata_kept", rdata_of(k), last_rd[k]);
                        end else begin
                            last_rd[k] = ref_mem[r_addr[k][5:2]];
                            chk("rnd_rdata", rdata_of(k), last_rd[k]);
                        end
                        act[k] = 1'b0;
                        set_m(k, 0, 0, '0, '0, '0);
                        r_gap[k] = int'($urandom_range(0, 3));
                    end else begin
                        r_wait[k]++;
                        if (r_wait[k] > 30) begin
                            chk1("rnd_timeout", ack_of(k), 1'b1);
                            act[k] = 1'b0;
                            set_m(k, 0, 0, '0, '0, '0);
                        end
                    end
                end else if (ack_of(k)) begin
                    chk1("rnd_spurious_ack", ack_of(k), 1'b0);
                end else if (r_gap[k] > 0) begin
                    r_gap[k]--;
                end else if (c < 650) begin
                    r_we[k]   = $urandom_range(0, 1) == 1;
                    r_addr[k] = 32'($urandom_range(0, 15) * 4);
                    r_sel[k]  = 4'($urandom_range(1, 15));
                    r_wd[k]   = $urandom;
                    r_wait[k] = 0;
                    act[k]    = 1'b1;
                    set_m(k, 1, r_we[k], r_addr[k], r_sel[k], r_wd[k]);
                end
            end
        end
        chk1("rnd_drained_m0", act[0], 1'b0);
        chk1("rnd_drained_m1", act[1], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
